// File: rtl/alu_vector_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alu_vector_sequencer_pkg
// Shared definitions for the ALU self-test sequencer:
//   - seq_state_t : sequencer FSM state encoding
//   - SEL_*       : the four ALU select codes carried in each vector
//   - *_lsb()     : bit offsets of the fields inside a packed vector
//                   {A[W-1:0], B[W-1:0], S[1:0], EXP[W-1:0]}
// ---------------------------------------------------------------------------
package alu_vector_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_FINISH = 3'd4
    } seq_state_t;

    // ALU select codes. The sequencer forwards S untouched; these name the
    // encodings a vector table may contain.
    localparam logic [1:0] SEL_OP0 = 2'b00;
    localparam logic [1:0] SEL_OP1 = 2'b01;
    localparam logic [1:0] SEL_OP2 = 2'b10;
    localparam logic [1:0] SEL_OP3 = 2'b11;

    // Field offsets within a (3W+2)-bit vector word.
    function automatic int exp_lsb(input int w);
        return 0;
    endfunction

    function automatic int sel_lsb(input int w);
        return w;
    endfunction

    function automatic int b_lsb(input int w);
        return w + 2;
    endfunction

    function automatic int a_lsb(input int w);
        return 2 * w + 2;
    endfunction

endpackage

// File: rtl/alu_vector_sequencer_table.sv
// ---------------------------------------------------------------------------
// alu_vector_table
// DEPTH x VW register file holding the test vectors. One synchronous write
// port, one asynchronous read port. Contents are intentionally not reset so a
// table survives a sequencer reset.
// Ports:
//   clk    in  clock
//   we     in  write enable (one entry per cycle)
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address
//   rdata  out read data (combinational)
// ---------------------------------------------------------------------------
module alu_vector_table #(
    parameter int VW    = 14,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [VW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [VW-1:0]            rdata
);

    logic [VW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_vector_sequencer.sv
// ---------------------------------------------------------------------------
// alu_vector_sequencer
// Self-test engine for a W-bit ALU. Holds a table of {A,B,S,EXP} vectors,
// drives each onto the ALU inputs, waits SETTLE cycles, compares the ALU
// result against EXP and keeps pass/fail counts plus the first failing index.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   vec_we/addr/data   table write port (honoured only while idle)
//   num_vec            number of vectors to run, sampled on start (clamped)
//   start              begin a run (accepted only while idle)
//   alu_a/alu_b/alu_s  registered drive to the ALU
//   alu_y              ALU result fed back
//   busy, done         run in progress / one-cycle end-of-run pulse
//   pass_cnt/fail_cnt  result counters for the current/last run
//   first_fail         index of the first mismatching vector
//   fail_seen          at least one mismatch in the current/last run
// Handshake: start is a level sampled on a clock edge while idle; a run is
// reported finished by exactly one cycle of done with busy already low.
// ---------------------------------------------------------------------------
module alu_vector_sequencer
    import alu_vector_sequencer_pkg::*;
#(
    parameter int W      = 4,
    parameter int DEPTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vec_we,
    input  logic [$clog2(DEPTH)-1:0] vec_addr,
    input  logic [3*W+1:0]           vec_data,
    input  logic [$clog2(DEPTH):0]   num_vec,
    input  logic                     start,
    output logic [W-1:0]             alu_a,
    output logic [W-1:0]             alu_b,
    output logic [1:0]               alu_s,
    input  logic [W-1:0]             alu_y,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   pass_cnt,
    output logic [$clog2(DEPTH):0]   fail_cnt,
    output logic [$clog2(DEPTH)-1:0] first_fail,
    output logic                     fail_seen
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int VW    = 3 * W + 2;
    localparam int SCW   = $clog2(SETTLE + 1);
    localparam int A_LSB = a_lsb(W);
    localparam int B_LSB = b_lsb(W);
    localparam int S_LSB = sel_lsb(W);
    localparam int E_LSB = exp_lsb(W);

    seq_state_t      state;
    seq_state_t      next_state;
    logic [AW-1:0]   idx;
    logic [CW-1:0]   num_q;
    logic [W-1:0]    exp_q;
    logic [SCW-1:0]  settle_cnt;
    logic [VW-1:0]   rd_data;
    logic            table_we;
    logic            last_vec;
    logic            settle_done;

    alu_vector_table #(
        .VW    (VW),
        .DEPTH (DEPTH)
    ) u_table (
        .clk   (clk),
        .we    (table_we),
        .waddr (vec_addr),
        .wdata (vec_data),
        .raddr (idx),
        .rdata (rd_data)
    );

    assign last_vec    = ({1'b0, idx} == (num_q - CW'(1)));
    // SETTLE state holds SETTLE-1 cycles: counter runs 0 .. SETTLE-2.
    assign settle_done = (settle_cnt == SCW'(SETTLE - 2));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = (num_vec == '0) ? ST_FINISH : ST_LOAD;
                end
            end
            ST_LOAD:   next_state = (SETTLE > 1) ? ST_SETTLE : ST_CHECK;
            ST_SETTLE: begin
                if (settle_done) begin
                    next_state = ST_CHECK;
                end
            end
            ST_CHECK:  next_state = last_vec ? ST_FINISH : ST_LOAD;
            ST_FINISH: next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy     = (state == ST_LOAD) || (state == ST_SETTLE) || (state == ST_CHECK);
        done     = (state == ST_FINISH);
        // Table frozen during a run; a write landing on the start edge is
        // visible to the first LOAD since the read port is asynchronous.
        table_we = vec_we && (state == ST_IDLE);
    end

    // Datapath and scoreboard
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_s      <= '0;
            exp_q      <= '0;
            idx        <= '0;
            num_q      <= '0;
            settle_cnt <= '0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            first_fail <= '0;
            fail_seen  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx        <= '0;
                        num_q      <= (num_vec > CW'(DEPTH)) ? CW'(DEPTH) : num_vec;
                        pass_cnt   <= '0;
                        fail_cnt   <= '0;
                        first_fail <= '0;
                        fail_seen  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    alu_a      <= rd_data[A_LSB +: W];
                    alu_b      <= rd_data[B_LSB +: W];
                    alu_s      <= rd_data[S_LSB +: 2];
                    exp_q      <= rd_data[E_LSB +: W];
                    settle_cnt <= '0;
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt + SCW'(1);
                end
                ST_CHECK: begin
                    if (alu_y == exp_q) begin
                        pass_cnt <= pass_cnt + CW'(1);
                    end else begin
                        fail_cnt <= fail_cnt + CW'(1);
                        if (!fail_seen) begin
                            first_fail <= idx;
                            fail_seen  <= 1'b1;
                        end
                    end
                    if (!last_vec) begin
                        idx <= idx + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
